// File: rtl/div_wrapper.sv
// Multi-cycle 32-bit radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Capture on start, 32 RUN steps, one FIX cycle; status is high while busy.
module div_wrapper (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        status,
  output logic        divide_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state, state_next;
  logic [4:0]  iter;
  logic [31:0] q_mag;     // dividend magnitude shifting out, quotient bits shifting in
  logic [31:0] r_mag;
  logic [31:0] dvs_mag;
  logic        q_neg, r_neg, dvs_zero;
  logic [32:0] r_shift, r_diff;

  function automatic logic [31:0] magnitude(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? (~x + 32'd1) : x;
  endfunction

  // One restoring step: shift in the next dividend bit, keep the difference if it fits.
  assign r_shift = {r_mag, q_mag[31]};
  assign r_diff  = r_shift - {1'b0, dvs_mag};

  assign status = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (iter == 5'd31) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: only the visible results and the step counter are reset; the working
  // operand registers are always reloaded on capture, so they carry no reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      quotient       <= '0;
      remainder      <= '0;
      divide_by_zero <= 1'b0;
      iter           <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          q_mag          <= magnitude(dividend, signed_div);
          dvs_mag        <= magnitude(divisor, signed_div);
          r_mag          <= '0;
          q_neg          <= signed_div & (dividend[31] ^ divisor[31]);
          r_neg          <= signed_div & dividend[31];
          dvs_zero       <= (divisor == 32'd0);
          divide_by_zero <= 1'b0;
          iter           <= '0;
        end
        RUN: begin
          q_mag <= {q_mag[30:0], ~r_diff[32]};
          r_mag <= r_diff[32] ? r_shift[31:0] : r_diff[31:0];
          iter  <= iter + 5'd1;
        end
        FIX: begin
          // Zero divisor: the remainder path already rebuilds the dividend; only the quotient is forced.
          quotient       <= dvs_zero ? 32'hFFFF_FFFF : (q_neg ? (~q_mag + 32'd1) : q_mag);
          remainder      <= r_neg ? (~r_mag + 32'd1) : r_mag;
          divide_by_zero <= dvs_zero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_wrapper.sv
// Self-checking bench for div_wrapper: reference results are queued at issue
// and compared when status falls.
module tb_div_wrapper;

  logic        clk_tb = 1'b0;
  logic        reset;
  logic        start;
  logic        signed_div;
  logic [31:0] dividend, divisor;
  logic [31:0] quotient, remainder;
  logic        status, divide_by_zero;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } expect_t;

  expect_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  div_wrapper dut (
    .clk           (clk_tb),
    .reset         (reset),
    .start         (start),
    .signed_div    (signed_div),
    .dividend      (dividend),
    .divisor       (divisor),
    .quotient      (quotient),
    .remainder     (remainder),
    .status        (status),
    .divide_by_zero(divide_by_zero)
  );

  always #5 clk_tb = ~clk_tb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic expect_t ref_div(input logic sd, input logic [31:0] a, input logic [31:0] b);
    expect_t e;
    int sa, sb;
    sa = a;
    sb = b;
    e.dz = 1'b0;
    if (b == 32'd0) begin
      e.q  = 32'hFFFF_FFFF;
      e.r  = a;
      e.dz = 1'b1;
    end else if (sd && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000;
      e.r = 32'd0;
    end else if (sd) begin
      e.q = 32'(sa / sb);
      e.r = 32'(sa % sb);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Issue one operation, optionally pulse start again while busy, then check on completion.
  task automatic run_op(input string tag, input logic sd, input logic [31:0] a,
                        input logic [31:0] b, input bit poke);
    expect_t e;
    int cycles;
    @(negedge clk_tb);
    start      = 1'b1;
    signed_div = sd;
    dividend   = a;
    divisor    = b;
    exp_q.push_back(ref_div(sd, a, b));
    @(negedge clk_tb);
    start      = 1'b0;
    signed_div = ~sd;
    dividend   = $urandom;
    divisor    = $urandom;
    cycles     = (status === 1'b1) ? 1 : 0;
    while (status === 1'b1 && cycles < 100) begin
      if (poke) start = (cycles == 10);
      @(negedge clk_tb);
      if (status === 1'b1) cycles++;
    end
    start = 1'b0;
    check({tag, " busy_cycles"}, 32'(cycles), 32'd33);
    if (exp_q.size() == 0) begin
      check({tag, " scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, " quotient"}, quotient, e.q);
      check({tag, " remainder"}, remainder, e.r);
      check({tag, " div_by_zero"}, 32'(divide_by_zero), 32'(e.dz));
    end
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    signed_div = 1'b0;
    dividend   = '0;
    divisor    = '0;
    repeat (3) @(negedge clk_tb);
    check("reset quotient", quotient, 32'd0);
    check("reset remainder", remainder, 32'd0);
    check("reset status", 32'(status), 32'd0);
    check("reset div_by_zero", 32'(divide_by_zero), 32'd0);
    reset = 1'b1;

    run_op("s 7/2",   1'b1, 32'd7,  32'd2,  1'b0);
    run_op("s -7/2",  1'b1, -32'd7, 32'd2,  1'b0);
    run_op("s 7/-2",  1'b1, 32'd7,  -32'd2, 1'b0);
    run_op("s -7/-2", 1'b1, -32'd7, -32'd2, 1'b0);
    run_op("u ffffffff/2", 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_op("s ffffffff/2", 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_op("s 100/0", 1'b1, 32'd100, 32'd0, 1'b0);
    run_op("s 9/3",   1'b1, 32'd9,   32'd3, 1'b0);
    run_op("u -5/0",  1'b0, -32'd5,  32'd0, 1'b0);
    run_op("s min/0", 1'b1, 32'h8000_0000, 32'd0, 1'b0);
    run_op("s overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("u min/-1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("busy start ignored", 1'b1, 32'd1000, -32'd7, 1'b1);

    // Abort an operation mid-RUN with reset.
    @(negedge clk_tb);
    start      = 1'b1;
    signed_div = 1'b0;
    dividend   = 32'd12345;
    divisor    = 32'd10;
    @(negedge clk_tb);
    start = 1'b0;
    repeat (10) @(negedge clk_tb);
    check("pre-abort status", 32'(status), 32'd1);
    reset = 1'b0;
    @(negedge clk_tb);
    check("abort status", 32'(status), 32'd0);
    check("abort quotient", quotient, 32'd0);
    check("abort remainder", remainder, 32'd0);
    check("abort div_by_zero", 32'(divide_by_zero), 32'd0);
    reset = 1'b1;
    run_op("after abort 9/3", 1'b1, 32'd9, 32'd3, 1'b0);

    // Sweep small magnitudes over all sign combinations.
    for (int i = 1; i <= 8; i++) begin
      for (int j = 1; j <= i; j++) begin
        for (int s = 0; s < 4; s++) begin
          logic [31:0] a, b;
          a = s[0] ? -32'(i) : 32'(i);
          b = s[1] ? -32'(j) : 32'(j);
          run_op("sweep", 1'b1, a, b, 1'b0);
        end
      end
    end

    for (int k = 0; k < 8; k++) begin
      run_op("rand u", 1'b0, $urandom, $urandom_range(1, 1 << 20), 1'b0);
      run_op("rand s", 1'b1, $urandom, $urandom, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
